// File: rtl/mul_seq.sv
// mul_seq - sequential signed shift-add multiplier.
//
// One partial product per clock on operand magnitudes, sign applied at the end.
// Start is accepted only in IDLE; the result appears WIDTH+1 edges later with a
// one-cycle done pulse.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   A, B   : WIDTH-bit signed operands, sampled on an accepted start
//   start  : multiply request, ignored while busy
//   S      : 2*WIDTH-bit signed product register, held until next completion
//   busy   : high while an operation is in progress
//   done   : one-cycle pulse, S valid in the same cycle
module mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [WIDTH-1:0]     A,
  input  logic signed [WIDTH-1:0]     B,
  input  logic                        start,
  output logic signed [2*WIDTH-1:0]   S,
  output logic                        busy,
  output logic                        done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t                     state_q, state_d;
  logic [WIDTH-1:0]           mcand_q, mcand_d;
  logic [WIDTH-1:0]           mplier_q, mplier_d;
  logic [2*WIDTH-1:0]         p_q, p_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       sign_q, sign_d;
  logic signed [2*WIDTH-1:0]  s_q, s_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic [WIDTH:0]             addend;
  logic [WIDTH:0]             sum;

  // Unsigned magnitude; the most negative value maps onto 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  // Two's-complement negate on request; -0 stays 0 naturally.
  function automatic logic signed [2*WIDTH-1:0] apply_sign(input logic neg,
                                                          input logic [2*WIDTH-1:0] mag);
    logic [2*WIDTH-1:0] r;
    r = neg ? (~mag + 1'b1) : mag;
    return $signed(r);
  endfunction

  // Upper half plus multiplicand, keeping the carry as bit WIDTH.
  assign addend = mplier_q[0] ? {1'b0, mcand_q} : '0;
  assign sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + addend;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    p_d      = p_q;
    count_d  = count_q;
    sign_d   = sign_q;
    s_d      = s_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = magnitude(A);
          mplier_d = magnitude(B);
          sign_d   = A[WIDTH-1] ^ B[WIDTH-1];
          p_d      = '0;
          count_d  = CW'(WIDTH);
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Shift {carry, P} right by one after the conditional add.
        p_d      = {sum, p_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        count_d  = count_q - 1'b1;
        if (count_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        s_d     = apply_sign(sign_q, p_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      p_q      <= '0;
      count_q  <= '0;
      sign_q   <= 1'b0;
      s_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      p_q      <= p_d;
      count_q  <= count_d;
      sign_q   <= sign_d;
      s_q      <= s_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign S    = s_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq - directed and random checks of mul_seq (WIDTH=16) with a
// scoreboard of expected products and acceptance edges.
module tb_mul_seq;

  localparam int W   = 16;
  localparam int LAT = W + 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic signed [W-1:0]     A;
  logic signed [W-1:0]     B;
  logic                    start;
  logic signed [2*W-1:0]   S;
  logic                    busy;
  logic                    done;

  typedef struct {
    logic [2*W-1:0] exp;
    int             edge_no;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  logic done_prev = 1'b0;

  mul_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .start (start),
    .S     (S),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every done pulse must match the oldest pending operation.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      assert (sb.size() > 0)
        else begin errors++; $error("FAIL unexpected_done got done=1 exp no pending op"); end
      if (sb.size() > 0) begin
        sb_t e;
        e = sb.pop_front();
        checks++;
        assert (S === e.exp)
          else begin errors++; $error("FAIL product got %h exp %h", S, e.exp); end
        checks++;
        assert (cyc - e.edge_no === LAT)
          else begin errors++; $error("FAIL latency got %0d exp %0d", cyc - e.edge_no, LAT); end
      end
      checks++;
      assert (done_prev === 1'b0)
        else begin errors++; $error("FAIL done_twice got %b exp 0", done_prev); end
    end
    done_prev = done;
  end

  // Drive operands and start at a negedge; the next rising edge accepts them.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
    sb_t e;
    e.exp     = exp;
    e.edge_no = cyc + 1;
    sb.push_back(e);
    A     = a;
    B     = b;
    start = 1'b1;
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint pa, pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 32'(pa * pb);
  endfunction

  // Wait (bounded) for done; busy must stay high until then and drop with it.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done) begin
        checks++;
        assert (busy === 1'b1)
          else begin errors++; $error("FAIL %s_busy got %b exp 1", tag, busy); end
      end
    end while (!done && n < 40);
    checks++;
    assert (done === 1'b1)
      else begin errors++; $error("FAIL %s_timeout got done=%b exp 1", tag, done); end
    checks++;
    assert (busy === 1'b0)
      else begin errors++; $error("FAIL %s_busy_fall got %b exp 0", tag, busy); end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp);
    issue(a, b, exp);
    @(negedge clk);
    start = 1'b0;
    checks++;
    assert (busy === 1'b1)
      else begin errors++; $error("FAIL %s_busy_rise got %b exp 1", tag, busy); end
    wait_done(tag);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    checks++;
    assert (S === 32'h0) else begin errors++; $error("FAIL reset_S got %h exp 0", S); end
    checks++;
    assert (busy === 1'b0) else begin errors++; $error("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    assert (done === 1'b0) else begin errors++; $error("FAIL reset_done got %b exp 0", done); end
    rst_n = 1'b1;
    @(negedge clk);

    do_op("basic", 16'd3, 16'd5, 32'h0000000F);
    do_op("neg_a", 16'hFFF9, 16'd6, 32'hFFFFFFD6);
    do_op("neg_b", 16'd6, 16'hFFF9, 32'hFFFFFFD6);
    do_op("neg_ab", 16'hFFF9, 16'hFFFA, 32'h0000002A);
    do_op("min_min", 16'h8000, 16'h8000, 32'h40000000);
    do_op("max_max", 16'h7FFF, 16'h7FFF, 32'h3FFF0001);
    do_op("min_one", 16'h8000, 16'h0001, 32'hFFFF8000);
    do_op("zero_min", 16'h0000, 16'h8000, 32'h00000000);

    // Start while busy: the second request must be ignored.
    issue(16'd2, 16'd3, 32'd6);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    A = 16'd9;
    B = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign_start");
    repeat (25) @(negedge clk);
    checks++;
    assert (sb.size() === 0)
      else begin errors++; $error("FAIL ign_pending got %0d exp 0", sb.size()); end

    // Reset mid-operation aborts without a done pulse and clears S.
    issue(16'd100, 16'd100, 32'd10000);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    assert (busy === 1'b0) else begin errors++; $error("FAIL abort_busy got %b exp 0", busy); end
    checks++;
    assert (done === 1'b0) else begin errors++; $error("FAIL abort_done got %b exp 0", done); end
    checks++;
    assert (S === 32'h0) else begin errors++; $error("FAIL abort_S got %h exp 0", S); end
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    checks++;
    assert (S === 32'h0) else begin errors++; $error("FAIL abort_hold_S got %h exp 0", S); end
    do_op("post_rst", 16'd4, 16'd4, 32'd16);

    // Back-to-back: start held high, new operands presented in each done cycle.
    for (int k = 0; k < 8; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      issue(ra, rb, ref_prod(ra, rb));
      wait_done("b2b");
    end
    start = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    checks++;
    assert (sb.size() === 0)
      else begin errors++; $error("FAIL b2b_pending got %0d exp 0", sb.size()); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
